// File: rtl/mul_err_sweep_if.sv
// Bus between the multiplier error-sweep harness and its environment:
// the start/busy/done handshake, the operand/product path to the
// multiplier under test, and the accumulated error metrics.
interface mul_err_sweep_if #(
   parameter int W = 6
);
   logic             start;
   logic             busy;
   logic             done;
   logic [W-1:0]     dut_a;
   logic [W-1:0]     dut_b;
   logic [2*W-1:0]   dut_p;
   logic [2*W:0]     err_count;
   logic [4*W-1:0]   sum_abs_err;
   logic [2*W-1:0]   max_abs_err;
   logic [W-1:0]     worst_a;
   logic [W-1:0]     worst_b;

   // Harness side: drives operands and metrics, consumes start and product.
   modport slave (
      input  start, dut_p,
      output busy, done, dut_a, dut_b,
             err_count, sum_abs_err, max_abs_err, worst_a, worst_b
   );

   // Environment side: requests sweeps, supplies the product, reads results.
   modport master (
      output start, dut_p,
      input  busy, done, dut_a, dut_b,
             err_count, sum_abs_err, max_abs_err, worst_a, worst_b
   );
endinterface

// File: rtl/mul_err_sweep.sv
// Exhaustive error-evaluation harness for a W x W unsigned multiplier.
// Issues every operand pair in sweep order, realigns the issued operands
// with the multiplier's PIPE-cycle latency, and accumulates error count,
// sum of absolute error and the first worst-case pair.
module mul_err_sweep #(
   parameter int W    = 6,
   parameter int PIPE = 0
) (
   input logic            clk,
   input logic            rst_n,
   mul_err_sweep_if.slave bus
);
   localparam int              CW         = 2 * W;
   localparam logic [CW-1:0]   CNT_LAST   = {CW{1'b1}};
   localparam logic [1:0]      DRAIN_LAST = 2'(PIPE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            issue_v_q, issue_v_d;
   logic [1:0]      drain_q, drain_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            clear_s;

   // operands as seen by the multiplier output after its latency
   logic            dly_v_s;
   logic [W-1:0]    dly_a_s;
   logic [W-1:0]    dly_b_s;

   logic [CW-1:0]   exact_s;
   logic [CW-1:0]   diff_s;

   logic            s1_v_q;
   logic            s1_ne_q;
   logic [CW-1:0]   s1_d_q;
   logic [W-1:0]    s1_a_q;
   logic [W-1:0]    s1_b_q;

   logic [CW:0]     err_q, err_d;
   logic [2*CW-1:0] sum_q, sum_d;
   logic [CW-1:0]   max_q, max_d;
   logic [W-1:0]    wa_q, wa_d;
   logic [W-1:0]    wb_q, wb_d;

   // Sweep control: start accept, operand counter, drain timing, status flags.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      issue_v_d = issue_v_q;
      drain_d   = drain_q;
      busy_d    = busy_q;
      done_d    = done_q;
      clear_s   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d   = ST_RUN;
               cnt_d     = {CW{1'b0}};
               issue_v_d = 1'b1;
               drain_d   = 2'd0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               clear_s   = 1'b1;
            end else begin
               state_d   = state_q;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d   = ST_DRAIN;
               cnt_d     = {CW{1'b0}};
               issue_v_d = 1'b0;
               drain_d   = 2'd0;
            end else begin
               cnt_d     = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            // last pair still travelling through the DUT latency and S1
            if (drain_q == DRAIN_LAST) begin
               state_d   = ST_DONE;
               drain_d   = 2'd0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               drain_d   = drain_q + 2'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = {CW{1'b0}};
            issue_v_d = 1'b0;
            drain_d   = 2'd0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
         end
      endcase
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CW{1'b0}};
         issue_v_q <= 1'b0;
         drain_q   <= 2'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         issue_v_q <= issue_v_d;
         drain_q   <= drain_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   generate
      if (PIPE == 0) begin : g_nopipe
         assign dly_v_s = issue_v_q;
         assign dly_a_s = cnt_q[W-1:0];
         assign dly_b_s = cnt_q[CW-1:W];
      end else begin : g_pipe
         logic [PIPE-1:0] v_q;
         logic [CW-1:0]   op_q [PIPE];

         // Delay issued operands and their valid by the DUT latency.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_q <= {PIPE{1'b0}};
               for (int i = 0; i < PIPE; i++) begin
                  op_q[i] <= {CW{1'b0}};
               end
            end else begin
               v_q[0]  <= issue_v_q;
               op_q[0] <= cnt_q;
               for (int i = 1; i < PIPE; i++) begin
                  v_q[i]  <= v_q[i-1];
                  op_q[i] <= op_q[i-1];
               end
            end
         end

         assign dly_v_s = v_q[PIPE-1];
         assign dly_a_s = op_q[PIPE-1][W-1:0];
         assign dly_b_s = op_q[PIPE-1][CW-1:W];
      end
   endgenerate

   // Exact reference product and unsigned error magnitude for the aligned pair.
   always_comb begin
      exact_s = CW'(dly_a_s) * CW'(dly_b_s);
      if (bus.dut_p >= exact_s) begin
         diff_s = bus.dut_p - exact_s;
      end else begin
         diff_s = exact_s - bus.dut_p;
      end
   end

   // Stage S1: capture the error of the aligned pair.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q  <= 1'b0;
         s1_ne_q <= 1'b0;
         s1_d_q  <= {CW{1'b0}};
         s1_a_q  <= {W{1'b0}};
         s1_b_q  <= {W{1'b0}};
      end else begin
         s1_v_q  <= dly_v_s & ~clear_s;
         s1_ne_q <= (diff_s != {CW{1'b0}});
         s1_d_q  <= diff_s;
         s1_a_q  <= dly_a_s;
         s1_b_q  <= dly_b_s;
      end
   end

   // Metric accumulation; strictly-greater keeps the first worst pair.
   always_comb begin
      err_d = err_q;
      sum_d = sum_q;
      max_d = max_q;
      wa_d  = wa_q;
      wb_d  = wb_q;
      if (clear_s) begin
         err_d = {(CW+1){1'b0}};
         sum_d = {(2*CW){1'b0}};
         max_d = {CW{1'b0}};
         wa_d  = {W{1'b0}};
         wb_d  = {W{1'b0}};
      end else if (s1_v_q) begin
         err_d = err_q + {{CW{1'b0}}, s1_ne_q};
         sum_d = sum_q + {{CW{1'b0}}, s1_d_q};
         if (s1_d_q > max_q) begin
            max_d = s1_d_q;
            wa_d  = s1_a_q;
            wb_d  = s1_b_q;
         end else begin
            max_d = max_q;
         end
      end else begin
         err_d = err_q;
      end
   end

   // Metric registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= {(CW+1){1'b0}};
         sum_q <= {(2*CW){1'b0}};
         max_q <= {CW{1'b0}};
         wa_q  <= {W{1'b0}};
         wb_q  <= {W{1'b0}};
      end else begin
         err_q <= err_d;
         sum_q <= sum_d;
         max_q <= max_d;
         wa_q  <= wa_d;
         wb_q  <= wb_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.dut_a       = cnt_q[W-1:0];
   assign bus.dut_b       = cnt_q[CW-1:W];
   assign bus.err_count   = err_q;
   assign bus.sum_abs_err = sum_q;
   assign bus.max_abs_err = max_q;
   assign bus.worst_a     = wa_q;
   assign bus.worst_b     = wb_q;

endmodule

// File: tb/tb_mul_err_sweep.sv
// Bench for mul_err_sweep: a combinational-DUT instance (PIPE=0) and a
// 2-cycle-DUT instance (PIPE=2), with behavioural multiplier models and a
// sweep-level reference model of the error metrics.
module tb_mul_err_sweep;
   localparam int W = 6;
   localparam int N = 4096;

   typedef struct {
      logic [63:0] err;
      logic [63:0] sum;
      logic [63:0] mx;
      logic [63:0] wa;
      logic [63:0] wb;
   } met_t;

   typedef struct {
      int   sel;
      int   mode;
      int   dly;
      int   edges;
      met_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   mode0 = 0;
   int   dly1 = 2;
   logic [11:0] got_tab [2][N];
   logic [11:0] r1, r2;
   vec_t vecs [7];

   always #5 clk = ~clk;

   mul_err_sweep_if #(.W(W)) bus0 ();
   mul_err_sweep_if #(.W(W)) bus1 ();

   mul_err_sweep #(.W(W), .PIPE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mul_err_sweep #(.W(W), .PIPE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   function automatic logic [11:0] exact_p(input logic [5:0] a, input logic [5:0] b);
      return 12'(a) * 12'(b);
   endfunction

   // Combinational multiplier models for the PIPE=0 instance.
   always_comb begin
      case (mode0)
         1:       bus0.dut_p = exact_p(bus0.dut_a, bus0.dut_b) & ~12'd1;
         2:       bus0.dut_p = 12'd0;
         3, 4:    bus0.dut_p = got_tab[mode0-3][{bus0.dut_b, bus0.dut_a}];
         default: bus0.dut_p = exact_p(bus0.dut_a, bus0.dut_b);
      endcase
   end

   // Exact multiplier with a register delay of one or two cycles.
   always_ff @(posedge clk) begin
      r1 <= exact_p(bus1.dut_a, bus1.dut_b);
      r2 <= r1;
   end
   assign bus1.dut_p = (dly1 == 1) ? r1 : r2;

   // Product the modelled DUT returns for sweep index idx (past the end: operands 0,0).
   function automatic logic [63:0] model_val(input int mode, input int idx);
      logic [63:0] p;
      if (idx >= N) p = 64'd0;
      else if (mode >= 3) p = 64'(got_tab[mode-3][idx]);
      else begin
         p = 64'((idx % 64) * (idx / 64));
         if (mode == 1) p = p & ~64'd1;
         else if (mode == 2) p = 64'd0;
      end
      return p;
   endfunction

   // Whole-sweep metrics: pair k is compared against the product of pair k+shift.
   function automatic met_t ref_model(input int mode, input int shift);
      met_t m;
      logic [63:0] ex, got, d;
      m.err = 64'd0; m.sum = 64'd0; m.mx = 64'd0; m.wa = 64'd0; m.wb = 64'd0;
      for (int k = 0; k < N; k++) begin
         ex  = 64'((k % 64) * (k / 64));
         got = model_val(mode, k + shift);
         d   = (got > ex) ? got - ex : ex - got;
         if (d != 64'd0) m.err = m.err + 64'd1;
         m.sum = m.sum + d;
         if (d > m.mx) begin
            m.mx = d; m.wa = 64'(k % 64); m.wb = 64'(k / 64);
         end
      end
      return m;
   endfunction

   function automatic vec_t mk(input int sel, input int mode, input int dly, input int edges,
                               input met_t e);
      vec_t v;
      v.sel = sel; v.mode = mode; v.dly = dly; v.edges = edges; v.exp = e;
      return v;
   endfunction

   function automatic met_t mm(input longint err, input longint sum, input longint mx,
                               input longint wa, input longint wb);
      met_t m;
      m.err = 64'(err); m.sum = 64'(sum); m.mx = 64'(mx); m.wa = 64'(wa); m.wb = 64'(wb);
      return m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic get_met(input int sel, output met_t m, output logic busy, output logic done);
      m.err = (sel != 0) ? 64'(bus1.err_count)   : 64'(bus0.err_count);
      m.sum = (sel != 0) ? 64'(bus1.sum_abs_err) : 64'(bus0.sum_abs_err);
      m.mx  = (sel != 0) ? 64'(bus1.max_abs_err) : 64'(bus0.max_abs_err);
      m.wa  = (sel != 0) ? 64'(bus1.worst_a)     : 64'(bus0.worst_a);
      m.wb  = (sel != 0) ? 64'(bus1.worst_b)     : 64'(bus0.worst_b);
      busy  = (sel != 0) ? bus1.busy : bus0.busy;
      done  = (sel != 0) ? bus1.done : bus0.done;
   endtask

   task automatic chk_met(input string tag, input met_t g, input met_t e);
      chk({tag, ".err_count"},   g.err, e.err);
      chk({tag, ".sum_abs_err"}, g.sum, e.sum);
      chk({tag, ".max_abs_err"}, g.mx,  e.mx);
      chk({tag, ".worst_a"},     g.wa,  e.wa);
      chk({tag, ".worst_b"},     g.wb,  e.wb);
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) bus1.start = v;
      else          bus0.start = v;
   endtask

   // Full sweep: accept edge E(0), then count edges until done rises.
   task automatic run_sweep(input int sel, input met_t e, input int edges, input string tag);
      met_t m;
      logic busy, done;
      int   n;
      bit   busy_drop;
      busy_drop = 1'b0;
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      get_met(sel, m, busy, done);
      chk({tag, ".accept_busy"}, 64'(busy), 64'd1);
      chk({tag, ".accept_done"}, 64'(done), 64'd0);
      chk({tag, ".accept_clear_err"}, m.err, 64'd0);
      chk({tag, ".accept_clear_max"}, m.mx, 64'd0);
      n = 0;
      for (int i = 1; i <= edges + 50; i++) begin
         @(posedge clk);
         #1;
         n = i;
         get_met(sel, m, busy, done);
         if (done) break;
         if (!busy) busy_drop = 1'b1;
      end
      if (!done) n = edges + 51;
      chk({tag, ".done_edge"}, 64'(n), 64'(edges));
      chk({tag, ".busy_held"}, 64'(busy_drop), 64'd0);
      chk({tag, ".busy_end"}, 64'(busy), 64'd0);
      chk_met(tag, m, e);
   endtask

   initial begin
      met_t m, zero, misal;
      logic busy, done;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      zero = mm(0, 0, 0, 0, 0);

      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) got_tab[t][k] = 12'($urandom_range(0, 4095));
            else got_tab[t][k] = 12'((k % 64) * (k / 64));
         end
      end

      misal   = ref_model(0, 1);
      vecs[0] = mk(0, 0, 2, 4097, zero);
      vecs[1] = mk(0, 2, 2, 4097, mm(3969, 4064256, 3969, 63, 63));
      vecs[2] = mk(0, 1, 2, 4097, mm(1024, 1024, 1, 1, 1));
      vecs[3] = mk(1, 0, 2, 4099, zero);
      vecs[4] = mk(1, 0, 1, 4099, misal);
      vecs[5] = mk(0, 3, 2, 4097, ref_model(3, 0));
      vecs[6] = mk(0, 4, 2, 4097, ref_model(4, 0));

      // reset state of both instances
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         get_met(s, m, busy, done);
         chk($sformatf("reset%0d.busy", s), 64'(busy), 64'd0);
         chk($sformatf("reset%0d.done", s), 64'(done), 64'd0);
         chk_met($sformatf("reset%0d", s), m, zero);
      end
      chk("reset.dut_ab", 64'({bus0.dut_b, bus0.dut_a}), 64'd0);

      // table-driven sweeps (consecutive vectors on one instance restart from DONE)
      for (int v = 0; v < 7; v++) begin
         mode0 = vecs[v].mode;
         dly1  = vecs[v].dly;
         run_sweep(vecs[v].sel, vecs[v].exp, vecs[v].edges, $sformatf("vec%0d", v));
      end
      chk("misalign.err_nonzero", 64'(misal.err != 64'd0), 64'd1);
      dly1 = 2;

      // back-to-back from DONE: random results replaced by bit-0 fault results
      mode0 = 1;
      run_sweep(0, mm(1024, 1024, 1, 1, 1), 4097, "b2b");

      // start during RUN is ignored; reset mid-sweep discards everything
      mode0 = 2;
      @(negedge clk);
      bus0.start = 1'b1;
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      bus0.start = 1'b1;
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
      chk("restart_ignored.op", 64'({bus0.dut_b, bus0.dut_a}), 64'd101);
      repeat (1898) @(posedge clk);
      #1;
      chk("pre_reset.err_nonzero", 64'(bus0.err_count != 13'd0), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      get_met(0, m, busy, done);
      chk("midreset.busy", 64'(busy), 64'd0);
      chk("midreset.done", 64'(done), 64'd0);
      chk_met("midreset", m, zero);
      chk("midreset.dut_ab", 64'({bus0.dut_b, bus0.dut_a}), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("midreset.idle_busy", 64'(bus0.busy), 64'd0);
      chk("midreset.idle_ab", 64'({bus0.dut_b, bus0.dut_a}), 64'd0);
      mode0 = 0;
      run_sweep(0, zero, 4097, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
